// File: rtl/cascade_counter_pkg.sv
// Shared constants and helpers for the mixed-radix cascade counter.
package cascade_counter_pkg;

   // Widest packed base vector the helpers accept (32 digits of 5-bit fields).
   localparam int BASES_MAX_W = 160;

   // MM:SS, digit 0 (seconds units) in the least significant field.
   localparam logic [19:0] MMSS_BASES = {5'd6, 5'd10, 5'd6, 5'd10};

   // HH:MM:SS for a 99:59:59 stopwatch range, seconds units in the LSB field.
   localparam logic [29:0] HHMMSS_BASES = {5'd10, 5'd10, 5'd6, 5'd10, 5'd6, 5'd10};

   // Extract the radix of digit i from a packed base vector of field_w-bit fields.
   function automatic int unsigned digit_base(input logic [BASES_MAX_W-1:0] bases,
                                              input int unsigned i,
                                              input int unsigned field_w = 32'd5);
      logic [BASES_MAX_W-1:0] mask;
      mask = (BASES_MAX_W'(1) << field_w) - BASES_MAX_W'(1);
      return 32'((bases >> (i * field_w)) & mask);
   endfunction

   // Limit a preset digit to the legal range 0..base-1.
   function automatic int unsigned clamp_digit(input int unsigned v, input int unsigned base);
      int unsigned r;
      if (v >= base) begin
         r = base - 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/cascade_counter_digit.sv
// One radix-BASE digit of the cascade: clear / preset / up-down step with wrap.
module cascade_digit
   import cascade_counter_pkg::*;
#(
   parameter int          DIGIT_BITS = 4,
   parameter int unsigned BASE       = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step,
   input  logic                  up_down,
   input  logic                  clear,
   input  logic                  load,
   input  logic [DIGIT_BITS-1:0] load_digit,
   output logic [DIGIT_BITS-1:0] value,
   output logic                  at_terminal
);

   localparam logic [DIGIT_BITS-1:0] MAX_VAL  = DIGIT_BITS'(BASE - 32'd1);
   localparam logic [DIGIT_BITS-1:0] ZERO_VAL = {DIGIT_BITS{1'b0}};
   localparam logic [DIGIT_BITS-1:0] ONE_VAL  = DIGIT_BITS'(32'd1);

   logic [DIGIT_BITS-1:0] next_val;
   logic [DIGIT_BITS-1:0] load_val;

   // Terminal value depends on the live direction: base-1 going up, 0 going down.
   assign at_terminal = up_down ? (value == MAX_VAL) : (value == ZERO_VAL);

   // Next digit value: clear beats load, load beats step; out-of-range presets are clamped.
   always_comb begin
      load_val = DIGIT_BITS'(clamp_digit(32'(load_digit), BASE));
      if (clear) begin
         if (up_down) begin
            next_val = ZERO_VAL;
         end else begin
            next_val = MAX_VAL;
         end
      end else if (load) begin
         next_val = load_val;
      end else if (step) begin
         if (up_down) begin
            next_val = (value == MAX_VAL) ? ZERO_VAL : value + ONE_VAL;
         end else begin
            next_val = (value == ZERO_VAL) ? MAX_VAL : value - ONE_VAL;
         end
      end else begin
         next_val = value;
      end
   end

   // Digit state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= ZERO_VAL;
      end else begin
         value <= next_val;
      end
   end

endmodule

// File: rtl/cascade_counter.sv
// N-digit mixed-radix up/down counter with wrap/saturate, clear, preset, lap capture.
module cascade_counter
   import cascade_counter_pkg::*;
#(
   parameter int                                    NUM_DIGITS  = 4,
   parameter int                                    DIGIT_BITS  = 4,
   parameter logic [NUM_DIGITS*(DIGIT_BITS+1)-1:0]  DIGIT_BASES = MMSS_BASES,
   parameter int                                    WRAP        = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic                             up_down,
   input  logic                             clear,
   input  logic                             load,
   input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
   input  logic                             lap,
   output logic [NUM_DIGITS*DIGIT_BITS-1:0] count,
   output logic [NUM_DIGITS*DIGIT_BITS-1:0] lap_count,
   output logic                             lap_valid,
   output logic                             terminal,
   output logic                             overflow
);

   localparam int                       W         = NUM_DIGITS * DIGIT_BITS;
   localparam int unsigned              FIELD_W   = DIGIT_BITS + 1;
   localparam logic [BASES_MAX_W-1:0]   BASES_EXT = BASES_MAX_W'(DIGIT_BASES);
   localparam logic                     WRAP_EN   = (WRAP != 0);

   logic [NUM_DIGITS-1:0] at_term;
   logic [NUM_DIGITS-1:0] lower_term;
   logic [NUM_DIGITS-1:0] step;
   logic [W-1:0]          digits;
   logic                  chain_acc;
   logic                  all_term;
   logic                  advance;

   // Carry AND-chain: digit i may step only when every lower digit is terminal.
   always_comb begin
      chain_acc = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         lower_term[i] = chain_acc;
         chain_acc     = chain_acc & at_term[i];
      end
      all_term = chain_acc;
   end

   // In saturate mode a fully terminal chain stops stepping; in wrap mode every digit rolls.
   always_comb begin
      advance = enable & (WRAP_EN | ~all_term);
      step    = lower_term & {NUM_DIGITS{advance}};
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      cascade_digit #(
         .DIGIT_BITS (DIGIT_BITS),
         .BASE       (digit_base(BASES_EXT, g, FIELD_W))
      ) u_digit (
         .clk         (clk),
         .rst         (rst),
         .step        (step[g]),
         .up_down     (up_down),
         .clear       (clear),
         .load        (load),
         .load_digit  (load_value[g*DIGIT_BITS +: DIGIT_BITS]),
         .value       (digits[g*DIGIT_BITS +: DIGIT_BITS]),
         .at_terminal (at_term[g])
      );
   end

   assign count    = digits;
   assign terminal = all_term;

   // Overflow pulses for one cycle after an enabled step taken from the full terminal state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= enable & all_term & ~clear & ~load;
      end
   end

   // Lap capture samples the pre-update count; clear drops the valid flag unless a lap coincides.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_count <= {W{1'b0}};
         lap_valid <= 1'b0;
      end else if (lap) begin
         lap_count <= digits;
         lap_valid <= 1'b1;
      end else if (clear) begin
         lap_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: a wrapping and a saturating instance share stimulus.
module tb_cascade_counter;
   import cascade_counter_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         up_down = 1'b1;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic         lap = 1'b0;
   logic [W-1:0] load_value = 16'h0000;

   logic [W-1:0] count_w, lap_count_w, count_s, lap_count_s;
   logic         lap_valid_w, terminal_w, overflow_w;
   logic         lap_valid_s, terminal_s, overflow_s;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] cnt_w;
      logic         ovf_w;
      logic [W-1:0] cnt_s;
      logic         ovf_s;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   always #5 clk = ~clk;

   cascade_counter #(.NUM_DIGITS(4), .DIGIT_BITS(4), .DIGIT_BASES(MMSS_BASES), .WRAP(1)) dut_w (
      .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
      .load_value(load_value), .lap(lap), .count(count_w), .lap_count(lap_count_w),
      .lap_valid(lap_valid_w), .terminal(terminal_w), .overflow(overflow_w));

   cascade_counter #(.NUM_DIGITS(4), .DIGIT_BITS(4), .DIGIT_BASES(MMSS_BASES), .WRAP(0)) dut_s (
      .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear), .load(load),
      .load_value(load_value), .lap(lap), .count(count_s), .lap_count(lap_count_s),
      .lap_valid(lap_valid_s), .terminal(terminal_s), .overflow(overflow_s));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preset(input logic [W-1:0] v);
      load_value = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (count_w !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %h want 0000", count_w); end
      n_cmp++; if (lap_count_w !== 16'h0000) begin n_bad++; $display("FAIL reset_lap_count: got %h want 0000", lap_count_w); end
      n_cmp++; if (lap_valid_w !== 1'b0) begin n_bad++; $display("FAIL reset_lap_valid: got %b want 0", lap_valid_w); end
      n_cmp++; if (overflow_w !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow_w); end
      n_cmp++; if (terminal_w !== 1'b0) begin n_bad++; $display("FAIL reset_terminal_up: got %b want 0", terminal_w); end
      up_down = 1'b0;
      #1;
      n_cmp++; if (terminal_w !== 1'b1) begin n_bad++; $display("FAIL reset_terminal_down: got %b want 1", terminal_w); end
      up_down = 1'b1;
      rst = 1'b0;
      tick();
      n_cmp++; if (count_w !== 16'h0000) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0000", count_w); end
   endtask

   task automatic test_up_carry();
      up_down = 1'b1;
      preset(16'h0959);
      enable = 1'b1;
      exp_q.push_back('{16'h1000, 1'b0, 16'h1000, 1'b0});
      tick();
      enable = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL up_carry_count: got %h want %h", count_w, e.cnt_w); end
      n_cmp++; if (overflow_w !== e.ovf_w) begin n_bad++; $display("FAIL up_carry_ovf: got %b want %b", overflow_w, e.ovf_w); end
      n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL up_carry_count_sat: got %h want %h", count_s, e.cnt_s); end
      n_cmp++; if (terminal_w !== 1'b0) begin n_bad++; $display("FAIL up_carry_terminal: got %b want 0", terminal_w); end
   endtask

   task automatic test_wrap_saturate();
      up_down = 1'b1;
      preset(16'h5959);
      n_cmp++; if (terminal_w !== 1'b1) begin n_bad++; $display("FAIL wrap_terminal_before: got %b want 1", terminal_w); end
      n_cmp++; if (terminal_s !== 1'b1) begin n_bad++; $display("FAIL sat_terminal_before: got %b want 1", terminal_s); end
      exp_q.push_back('{16'h0000, 1'b1, 16'h5959, 1'b1});
      exp_q.push_back('{16'h0001, 1'b0, 16'h5959, 1'b1});
      exp_q.push_back('{16'h0001, 1'b0, 16'h5959, 1'b0});
      for (int i = 0; i < 3; i++) begin
         enable = (i < 2);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL wrap_count[%0d]: got %h want %h", i, count_w, e.cnt_w); end
         n_cmp++; if (overflow_w !== e.ovf_w) begin n_bad++; $display("FAIL wrap_ovf[%0d]: got %b want %b", i, overflow_w, e.ovf_w); end
         n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL sat_count[%0d]: got %h want %h", i, count_s, e.cnt_s); end
         n_cmp++; if (overflow_s !== e.ovf_s) begin n_bad++; $display("FAIL sat_ovf[%0d]: got %b want %b", i, overflow_s, e.ovf_s); end
      end
      enable = 1'b0;
   endtask

   task automatic test_down_borrow_clear();
      preset(16'h1000);
      up_down = 1'b0;
      exp_q.push_back('{16'h0959, 1'b0, 16'h0959, 1'b0});
      exp_q.push_back('{16'h5959, 1'b0, 16'h5959, 1'b0});
      for (int i = 0; i < 2; i++) begin
         enable = (i == 0);
         clear  = (i == 1);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL down_count[%0d]: got %h want %h", i, count_w, e.cnt_w); end
         n_cmp++; if (overflow_w !== e.ovf_w) begin n_bad++; $display("FAIL down_ovf[%0d]: got %b want %b", i, overflow_w, e.ovf_w); end
         n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL down_count_sat[%0d]: got %h want %h", i, count_s, e.cnt_s); end
      end
      clear = 1'b0;
      n_cmp++; if (terminal_w !== 1'b0) begin n_bad++; $display("FAIL down_terminal_at_max: got %b want 0", terminal_w); end
      preset(16'h0000);
      enable = 1'b1;
      exp_q.push_back('{16'h5959, 1'b1, 16'h0000, 1'b1});
      tick();
      enable = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL down_wrap_count: got %h want %h", count_w, e.cnt_w); end
      n_cmp++; if (overflow_w !== e.ovf_w) begin n_bad++; $display("FAIL down_wrap_ovf: got %b want %b", overflow_w, e.ovf_w); end
      n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL down_sat_count: got %h want %h", count_s, e.cnt_s); end
      n_cmp++; if (overflow_s !== e.ovf_s) begin n_bad++; $display("FAIL down_sat_ovf: got %b want %b", overflow_s, e.ovf_s); end
      up_down = 1'b1;
   endtask

   task automatic test_load_clamp();
      exp_q.push_back('{16'h5959, 1'b0, 16'h5959, 1'b0});
      preset(16'h7A99);
      e = exp_q.pop_front();
      n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL load_clamp: got %h want %h", count_w, e.cnt_w); end
      n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL load_clamp_sat: got %h want %h", count_s, e.cnt_s); end
   endtask

   task automatic test_priority();
      up_down = 1'b1;
      preset(16'h5959);
      exp_q.push_back('{16'h0000, 1'b0, 16'h0000, 1'b0});
      exp_q.push_back('{16'h0234, 1'b0, 16'h0234, 1'b0});
      for (int i = 0; i < 2; i++) begin
         clear = (i == 0);
         load = 1'b1;
         enable = 1'b1;
         load_value = (i == 0) ? 16'h1234 : 16'h0234;
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL priority_count[%0d]: got %h want %h", i, count_w, e.cnt_w); end
         n_cmp++; if (overflow_w !== e.ovf_w) begin n_bad++; $display("FAIL priority_ovf[%0d]: got %b want %b", i, overflow_w, e.ovf_w); end
         n_cmp++; if (overflow_s !== e.ovf_s) begin n_bad++; $display("FAIL priority_ovf_sat[%0d]: got %b want %b", i, overflow_s, e.ovf_s); end
      end
      clear = 1'b0;
      load = 1'b0;
      enable = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_tab [6];
      logic         dir_tab [6];
      exp_tab = '{16'h0958, 16'h0959, 16'h1000, 16'h1001, 16'h1000, 16'h0959};
      dir_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      up_down = 1'b1;
      preset(16'h0957);
      up_down = 1'b0;
      tick();
      n_cmp++; if (count_w !== 16'h0957) begin n_bad++; $display("FAIL dir_change_no_effect: got %h want 0957", count_w); end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         up_down = dir_tab[i];
         exp_q.push_back('{exp_tab[i], 1'b0, exp_tab[i], 1'b0});
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (count_w !== e.cnt_w) begin n_bad++; $display("FAIL b2b_count[%0d]: got %h want %h", i, count_w, e.cnt_w); end
         n_cmp++; if (count_s !== e.cnt_s) begin n_bad++; $display("FAIL b2b_count_sat[%0d]: got %h want %h", i, count_s, e.cnt_s); end
      end
      enable = 1'b0;
      up_down = 1'b1;
   endtask

   task automatic test_lap_reset();
      up_down = 1'b1;
      preset(16'h0123);
      lap = 1'b1;
      enable = 1'b1;
      tick();
      n_cmp++; if (lap_count_w !== 16'h0123) begin n_bad++; $display("FAIL lap_capture: got %h want 0123", lap_count_w); end
      n_cmp++; if (count_w !== 16'h0124) begin n_bad++; $display("FAIL lap_count_step: got %h want 0124", count_w); end
      n_cmp++; if (lap_valid_w !== 1'b1) begin n_bad++; $display("FAIL lap_valid_set: got %b want 1", lap_valid_w); end
      enable = 1'b0;
      clear = 1'b1;
      tick();
      n_cmp++; if (lap_count_w !== 16'h0124) begin n_bad++; $display("FAIL lap_with_clear: got %h want 0124", lap_count_w); end
      n_cmp++; if (lap_valid_w !== 1'b1) begin n_bad++; $display("FAIL lap_valid_with_clear: got %b want 1", lap_valid_w); end
      n_cmp++; if (count_w !== 16'h0000) begin n_bad++; $display("FAIL clear_with_lap: got %h want 0000", count_w); end
      lap = 1'b0;
      tick();
      clear = 1'b0;
      n_cmp++; if (lap_valid_w !== 1'b0) begin n_bad++; $display("FAIL clear_drops_valid: got %b want 0", lap_valid_w); end
      n_cmp++; if (lap_count_w !== 16'h0124) begin n_bad++; $display("FAIL clear_keeps_lap: got %h want 0124", lap_count_w); end
      preset(16'h5959);
      lap = 1'b1;
      enable = 1'b1;
      tick();
      lap = 1'b0;
      enable = 1'b0;
      n_cmp++; if (overflow_w !== 1'b1) begin n_bad++; $display("FAIL pre_reset_ovf: got %b want 1", overflow_w); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (count_w !== 16'h0000) begin n_bad++; $display("FAIL async_rst_count: got %h want 0000", count_w); end
      n_cmp++; if (count_s !== 16'h0000) begin n_bad++; $display("FAIL async_rst_count_sat: got %h want 0000", count_s); end
      n_cmp++; if (lap_count_w !== 16'h0000) begin n_bad++; $display("FAIL async_rst_lap: got %h want 0000", lap_count_w); end
      n_cmp++; if (lap_valid_w !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", lap_valid_w); end
      n_cmp++; if (overflow_w !== 1'b0) begin n_bad++; $display("FAIL async_rst_ovf: got %b want 0", overflow_w); end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_up_carry();
      test_wrap_saturate();
      test_down_borrow_clear();
      test_load_clamp();
      test_priority();
      test_back_to_back();
      test_lap_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised multi-digit counter built from a chain of mixed-radix digits, each with its own base, for the stopwatch time-keeping path. It generalises the single-digit up/down counter to N cascaded digits with per-digit radix, selectable wrap or saturate behaviour, synchronous clear and preset load, a lap-capture register and an overflow pulse. It sits between the tick generator and the display/BCD-to-segment path; `count` feeds the display and `lap_count` feeds the lap display mux.

## Interface
- `NUM_DIGITS`, 4: number of cascaded digits; digit 0 is least significant.
- `DIGIT_BITS`, 4: width of each digit field.
- `DIGIT_BASES`, {5'd6,5'd10,5'd6,5'd10}: packed per-digit radix.
  - Each field is `DIGIT_BITS+1` bits; digit 0 is in the LSB field.
  - The default gives MM:SS.
  - Each base must lie in 2..2^DIGIT_BITS.
- `WRAP`, 1: selects terminal behaviour. 1 means wrap around at the terminal value; 0 means saturate.
- Let W = NUM_DIGITS*DIGIT_BITS.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: count tick; one step per cycle while high.
- `up_down` in 1: count direction; 1 counts up, 0 counts down.
- `clear` in 1: synchronous restart to the start value for the current direction.
- `load` in 1: synchronous preset from `load_value`.
- `load_value` in W: preset value, one digit per field.
- `lap` in 1: snapshot request.
- `count` out W: current value, registered.
- `lap_count` out W: last snapshot, registered.
- `lap_valid` out 1: sticky flag meaning `lap_count` holds a snapshot.
- `terminal` out 1: combinational; high when every digit is at its terminal value for the current direction.
- `overflow` out 1: registered one-cycle pulse.

## Operation
- Digit terminal value:
  - Up: base-1.
  - Down: 0.
- Carry chain: digit i steps when `enable` is high and every digit j<i is at its terminal value.
  - Digit 0 steps on every enabled cycle.
  - Stepping up goes v→v+1, or base-1→0.
  - Stepping down goes v→v-1, or 0→base-1.
- Full-chain terminal (`terminal`=1) with `enable`=1:
  - WRAP=1: all digits wrap, giving 0 up or the all-max value down. `overflow` pulses.
  - WRAP=0: `count` holds. `overflow` pulses on each such enabled cycle.
- Priority per edge: `clear` > `load` > `enable`.
  - `clear` sets `count` to 0 when counting up, or to the all-max value (every digit at base-1) when counting down.
  - `load` sets each digit to its field of `load_value`. A field ≥ base is clamped to base-1.
  - Neither `clear` nor `load` pulses `overflow`.
- `up_down` changes never alter `count` directly. The new direction applies from the next step.
- `lap` is independent of the priority chain.
  - On an edge with `lap`=1, `lap_count` takes the `count` value present before that edge, i.e. the pre-update value.
  - The same edge sets `lap_valid`=1.
  - `clear` resets `lap_valid` to 0. `lap_count` keeps its value.
  - If `lap` and `clear` occur together, the snapshot is taken and `lap_valid` stays 1.
- `count` digits are always within 0..base-1. No illegal state is reachable.

## Timing
- Reset values: `count`=0 whatever `up_down` is, `lap_count`=0, `lap_valid`=0, `overflow`=0.
  - `terminal` follows `count` and `up_down` combinationally, so after reset it is 1 if `up_down`=0 and 0 otherwise.
- Latency:
  - `enable`, `clear` and `load` act on the next rising edge, so `count` updates 1 cycle later.
  - `lap_count` updates 1 cycle after `lap`.
- `overflow` is high for exactly the cycle following the terminal-step edge, aligned with the new `count`.
- `terminal` has zero latency from `count` and `up_down`. Downstream logic must register it before any cross-block use.
- Reset mid-count: `rst` asserted at any time clears all state immediately. The first step after release takes effect at the first edge with `enable`=1.

## Structure
- `cascade_counter_pkg` holds:
  - the default MM:SS base constant;
  - the HH:MM:SS base constant;
  - a function `digit_base(bases, i)` that extracts field i;
  - a function `clamp_digit(v, base)`.
- Sub-module `cascade_digit`, one per digit via generate. Each instance has:
  - inputs `clk`, `rst`, `step`, `up_down`, `clear`, `load`, `load_digit`, and `BASE` as a parameter;
  - outputs `value` and `at_terminal`.
- The top level builds the carry AND-chain, the wrap/saturate gating, the overflow register and the lap register.

## Test plan
All scenarios use the default parameters unless stated.
- Up carry: `count`=0x0959, `up_down`=1, one `enable` → `count`=0x1000, `overflow`=0, `terminal`=0.
- Up wrap/saturate: `count`=0x5959, `up_down`=1, one `enable`.
  - WRAP=1 → 0x0000, with `overflow` high for exactly 1 cycle.
  - WRAP=0 → 0x5959 holds, `overflow` pulses, and a second enable pulses it again.
- Down borrow and clear: `count`=0x1000, `up_down`=0, one `enable` → 0x0959. Then `clear` → 0x5959.
- Load clamp: `load_value`=0x7A99, `load`=1 → `count`=0x5959.
- Priority: `clear`, `load` and `enable` in the same cycle with `up_down`=1 → `count`=0x0000.
- Lap and reset: `count`=0x0123, `lap` and `enable` on the same edge → `lap_count`=0x0123, `count`=0x0124, `lap_valid`=1.
  - Then `rst` mid-cycle → all outputs return to reset values immediately, without waiting for a clock edge.
